// File: rtl/fix_line_fetch.sv
// fix_line_fetch: per-scanline fix-layer fetcher.
// Walks the 40 map columns of one scanline. Each column takes one VRAM map read
// and two fix ROM reads, and writes two four-pixel quads into the line buffer.
module fix_line_fetch (
    input  logic        clk,
    input  logic        rstn,
    input  logic        linestart,
    input  logic [7:0]  line,
    output logic        busy,
    output logic        done,
    output logic        vreq,
    output logic [10:0] vaddr,
    input  logic        vack,
    input  logic [15:0] vdata,
    output logic        msreq,
    output logic [16:0] msaddr,
    input  logic        msack,
    input  logic [15:0] msdata,
    output logic        pxwe,
    output logic [6:0]  pxaddr,
    output logic [31:0] pxdata
);

    localparam int unsigned NCOLS    = 40;
    localparam logic [5:0]  LAST_COL = 6'(NCOLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAP,
        S_ROMA,
        S_ROMB,
        S_FIN
    } state_t;

    // REQ is only used for the first access of a line; later accesses
    // raise their request directly on leaving the previous GAP.
    typedef enum logic [1:0] {
        PH_REQ,
        PH_WAIT,
        PH_GAP
    } phase_t;

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [5:0]  col_q, col_d;
    logic [7:0]  line_q, line_d;
    logic [3:0]  pal_q, pal_d;
    logic [11:0] tile_q, tile_d;

    logic        busy_d, done_d, vreq_d, msreq_d, pxwe_d;
    logic [10:0] vaddr_d;
    logic [16:0] msaddr_d;
    logic [6:0]  pxaddr_d;
    logic [31:0] pxdata_d;

    logic [10:0] map_addr_c;
    logic [10:0] next_map_addr_c;
    logic [16:0] roma_addr_c;
    logic [16:0] romb_addr_c;
    logic [31:0] quad_c;

    // Address and pixel formatting shared by the state machine.
    always_comb begin
        map_addr_c      = {col_q, line_q[7:3]};
        next_map_addr_c = {6'(col_q + 6'd1), line_q[7:3]};
        roma_addr_c     = {tile_q, 1'b1, 1'b0, line_q[2:0]};
        romb_addr_c     = {tile_q, 1'b0, 1'b0, line_q[2:0]};
        quad_c          = {pal_q, msdata[15:12], pal_q, msdata[11:8],
                           pal_q, msdata[7:4],   pal_q, msdata[3:0]};
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            phase_q <= PH_REQ;
            col_q   <= '0;
            line_q  <= '0;
            pal_q   <= '0;
            tile_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            vreq    <= 1'b0;
            vaddr   <= '0;
            msreq   <= 1'b0;
            msaddr  <= '0;
            pxwe    <= 1'b0;
            pxaddr  <= '0;
            pxdata  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            col_q   <= col_d;
            line_q  <= line_d;
            pal_q   <= pal_d;
            tile_q  <= tile_d;
            busy    <= busy_d;
            done    <= done_d;
            vreq    <= vreq_d;
            vaddr   <= vaddr_d;
            msreq   <= msreq_d;
            msaddr  <= msaddr_d;
            pxwe    <= pxwe_d;
            pxaddr  <= pxaddr_d;
            pxdata  <= pxdata_d;
        end
    end

    // Next-state and next-output logic; acks only count in the WAIT phase.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        col_d    = col_q;
        line_d   = line_q;
        pal_d    = pal_q;
        tile_d   = tile_q;
        busy_d   = busy;
        done_d   = 1'b0;
        vreq_d   = vreq;
        vaddr_d  = vaddr;
        msreq_d  = msreq;
        msaddr_d = msaddr;
        pxwe_d   = 1'b0;
        pxaddr_d = pxaddr;
        pxdata_d = pxdata;

        case (state_q)
            S_IDLE: begin
                if (linestart) begin
                    line_d  = line;
                    col_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_MAP;
                    phase_d = PH_REQ;
                end
            end

            S_MAP: begin
                case (phase_q)
                    PH_REQ: begin
                        vreq_d  = 1'b1;
                        vaddr_d = map_addr_c;
                        phase_d = PH_WAIT;
                    end
                    PH_WAIT: begin
                        if (vack) begin
                            pal_d   = vdata[15:12];
                            tile_d  = vdata[11:0];
                            vreq_d  = 1'b0;
                            phase_d = PH_GAP;
                        end
                    end
                    PH_GAP: begin
                        msreq_d  = 1'b1;
                        msaddr_d = roma_addr_c;
                        state_d  = S_ROMA;
                        phase_d  = PH_WAIT;
                    end
                    default: phase_d = PH_REQ;
                endcase
            end

            S_ROMA: begin
                case (phase_q)
                    PH_REQ: begin
                        msreq_d  = 1'b1;
                        msaddr_d = roma_addr_c;
                        phase_d  = PH_WAIT;
                    end
                    PH_WAIT: begin
                        if (msack) begin
                            msreq_d  = 1'b0;
                            pxwe_d   = 1'b1;
                            pxaddr_d = {col_q, 1'b0};
                            pxdata_d = quad_c;
                            phase_d  = PH_GAP;
                        end
                    end
                    PH_GAP: begin
                        msreq_d  = 1'b1;
                        msaddr_d = romb_addr_c;
                        state_d  = S_ROMB;
                        phase_d  = PH_WAIT;
                    end
                    default: phase_d = PH_REQ;
                endcase
            end

            S_ROMB: begin
                case (phase_q)
                    PH_REQ: begin
                        msreq_d  = 1'b1;
                        msaddr_d = romb_addr_c;
                        phase_d  = PH_WAIT;
                    end
                    PH_WAIT: begin
                        if (msack) begin
                            msreq_d  = 1'b0;
                            pxwe_d   = 1'b1;
                            pxaddr_d = {col_q, 1'b1};
                            pxdata_d = quad_c;
                            phase_d  = PH_GAP;
                        end
                    end
                    PH_GAP: begin
                        if (col_q == LAST_COL) begin
                            state_d = S_FIN;
                            phase_d = PH_REQ;
                        end else begin
                            col_d   = 6'(col_q + 6'd1);
                            vreq_d  = 1'b1;
                            vaddr_d = next_map_addr_c;
                            state_d = S_MAP;
                            phase_d = PH_WAIT;
                        end
                    end
                    default: phase_d = PH_REQ;
                endcase
            end

            S_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
                phase_d = PH_REQ;
            end

            default: begin
                state_d = S_IDLE;
                phase_d = PH_REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_fix_line_fetch.sv
// Testbench for fix_line_fetch: responders for VRAM and fix ROM, a line-level
// reference model feeding expectation queues, and a monitor that checks outputs.
module tb_fix_line_fetch;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        linestart = 1'b0;
    logic [7:0]  line = 8'd0;
    logic        busy, done, vreq, msreq, pxwe;
    logic [10:0] vaddr;
    logic [16:0] msaddr;
    logic [6:0]  pxaddr;
    logic [31:0] pxdata;
    logic        vack = 1'b0;
    logic        msack = 1'b0;
    logic [15:0] vdata = 16'd0;
    logic [15:0] msdata = 16'd0;

    fix_line_fetch dut (
        .clk(clk), .rstn(rstn), .linestart(linestart), .line(line),
        .busy(busy), .done(done), .vreq(vreq), .vaddr(vaddr),
        .vack(vack), .vdata(vdata), .msreq(msreq), .msaddr(msaddr),
        .msack(msack), .msdata(msdata), .pxwe(pxwe), .pxaddr(pxaddr),
        .pxdata(pxdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expectations produced by the reference model.
    logic [10:0] exp_va[$];
    logic [16:0] exp_ma[$];
    logic [38:0] exp_wr[$];
    int          exp_done[$];

    // Responder configuration and memory contents.
    bit          rom_const = 1'b1;
    bit          rand_dly = 1'b0;
    bit          echo_mode = 1'b0;
    int          fix_dly = 1;
    logic [15:0] vram_mem [0:2047];

    function automatic logic [15:0] rom_fn(input logic [16:0] a);
        logic [31:0] x;
        x = {15'd0, a} * 32'h9E3779B1;
        return rom_const ? 16'h4321 : (x[31:16] ^ x[15:0]);
    endfunction

    // Reference model: the whole line's expected traffic from the geometry rules.
    task automatic model_line(input logic [7:0] l);
        logic [10:0] va;
        logic [15:0] e;
        logic [16:0] ma;
        logic [15:0] w;
        logic [31:0] d;
        int q;
        for (int c = 0; c < 40; c++) begin
            va = {6'(c), l[7:3]};
            exp_va.push_back(va);
            e = vram_mem[va];
            for (int h = 1; h >= 0; h--) begin
                ma = {e[11:0], 1'(h), 1'b0, l[2:0]};
                exp_ma.push_back(ma);
                w = rom_fn(ma);
                q = 2 * c + (1 - h);
                for (int k = 0; k < 4; k++) d[8*k +: 8] = {e[15:12], w[4*k +: 4]};
                exp_wr.push_back({7'(q), d});
            end
        end
    endtask

    // VRAM responder: ack after a delay, optionally echoed for one extra cycle.
    logic        v_pend = 1'b0, v_echoed = 1'b0;
    int          v_cnt = 0;
    int          v_rnd = 1;
    logic [10:0] v_al = 11'd0;
    always @(posedge clk) begin
        if (vack) begin
            if (echo_mode && !v_echoed) v_echoed <= 1'b1;
            else begin
                vack     <= 1'b0;
                v_echoed <= 1'b0;
                vdata    <= 16'($urandom);
                v_rnd    <= int'($urandom_range(1, 7));
            end
        end else if (v_pend) begin
            if (v_cnt <= 1) begin
                vack   <= 1'b1;
                vdata  <= vram_mem[v_al];
                v_pend <= 1'b0;
            end else v_cnt <= v_cnt - 1;
        end else if (vreq) begin
            if ((rand_dly ? v_rnd : fix_dly) == 1) begin
                vack  <= 1'b1;
                vdata <= vram_mem[vaddr];
            end else begin
                v_pend <= 1'b1;
                v_cnt  <= (rand_dly ? v_rnd : fix_dly) - 1;
                v_al   <= vaddr;
            end
        end
    end

    // Fix ROM responder, same behaviour as the VRAM one.
    logic        m_pend = 1'b0, m_echoed = 1'b0;
    int          m_cnt = 0;
    int          m_rnd = 1;
    logic [16:0] m_al = 17'd0;
    always @(posedge clk) begin
        if (msack) begin
            if (echo_mode && !m_echoed) m_echoed <= 1'b1;
            else begin
                msack    <= 1'b0;
                m_echoed <= 1'b0;
                msdata   <= 16'($urandom);
                m_rnd    <= int'($urandom_range(1, 7));
            end
        end else if (m_pend) begin
            if (m_cnt <= 1) begin
                msack  <= 1'b1;
                msdata <= rom_fn(m_al);
                m_pend <= 1'b0;
            end else m_cnt <= m_cnt - 1;
        end else if (msreq) begin
            if ((rand_dly ? m_rnd : fix_dly) == 1) begin
                msack  <= 1'b1;
                msdata <= rom_fn(msaddr);
            end else begin
                m_pend <= 1'b1;
                m_cnt  <= (rand_dly ? m_rnd : fix_dly) - 1;
                m_al   <= msaddr;
            end
        end
    end

    // Monitor: compares DUT outputs against the expectation queues.
    logic        pv_vreq = 1'b0, pv_msreq = 1'b0, pv_vack = 1'b0, pv_msack = 1'b0;
    logic [10:0] m_va;
    logic [16:0] m_ma;
    logic [38:0] m_wr;
    int          m_lat;
    always @(negedge clk) begin
        if (!rstn) begin
            checks++;
            if ({busy, done, vreq, vaddr, msreq, msaddr, pxwe, pxaddr, pxdata} != '0) begin
                errors++;
                $display("FAIL reset_outputs got=%h required=0",
                         {busy, done, vreq, vaddr, msreq, msaddr, pxwe, pxaddr, pxdata});
            end
        end else begin
            if (vreq || msreq) begin
                checks++;
                if (vreq && msreq) begin
                    errors++;
                    $display("FAIL both_req vreq=%b msreq=%b required one at most", vreq, msreq);
                end
            end
            if (pv_vreq && !vreq) begin
                checks++;
                if (!pv_vack) begin
                    errors++;
                    $display("FAIL vreq_hold dropped with vack=%b required 1", pv_vack);
                end
            end
            if (pv_msreq && !msreq) begin
                checks++;
                if (!pv_msack) begin
                    errors++;
                    $display("FAIL msreq_hold dropped with msack=%b required 1", pv_msack);
                end
            end
            if (vreq && !pv_vreq) begin
                checks++;
                if (exp_va.size() == 0) begin
                    errors++;
                    $display("FAIL vaddr unexpected request got=%h required none", vaddr);
                end else begin
                    m_va = exp_va.pop_front();
                    if (vaddr != m_va) begin
                        errors++;
                        $display("FAIL vaddr got=%h required=%h", vaddr, m_va);
                    end
                end
            end
            if (msreq && !pv_msreq) begin
                checks++;
                if (exp_ma.size() == 0) begin
                    errors++;
                    $display("FAIL msaddr unexpected request got=%h required none", msaddr);
                end else begin
                    m_ma = exp_ma.pop_front();
                    if (msaddr != m_ma) begin
                        errors++;
                        $display("FAIL msaddr got=%h required=%h", msaddr, m_ma);
                    end
                end
            end
            if (pxwe) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL pxwe unexpected write addr=%0d data=%h", pxaddr, pxdata);
                end else begin
                    m_wr = exp_wr.pop_front();
                    if ({pxaddr, pxdata} != m_wr) begin
                        errors++;
                        $display("FAIL pxwrite got addr=%0d data=%h required addr=%0d data=%h",
                                 pxaddr, pxdata, m_wr[38:32], m_wr[31:0]);
                    end
                end
            end
            if (done) begin
                checks++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL done unexpected pulse at cycle %0d", cyc);
                end else begin
                    m_lat = exp_done.pop_front();
                    if (exp_wr.size() != 0 || busy) begin
                        errors++;
                        $display("FAIL done_state writes_left=%0d busy=%b required 0 and 0",
                                 exp_wr.size(), busy);
                    end
                    if (m_lat != 0) begin
                        checks++;
                        if (cyc - t0 != m_lat) begin
                            errors++;
                            $display("FAIL done_latency got=%0d required=%0d", cyc - t0, m_lat);
                        end
                    end
                end
            end
        end
        pv_vreq  <= vreq;
        pv_msreq <= msreq;
        pv_vack  <= vack;
        pv_msack <= msack;
    end

    task automatic start_line(input logic [7:0] l, input int lat);
        model_line(l);
        exp_done.push_back(lat);
        @(negedge clk); #1;
        line = l;
        linestart = 1'b1;
        @(negedge clk);
        t0 = cyc;
        #1 linestart = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n;
        n = 0;
        while (exp_done.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (exp_done.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout no done within %0d cycles", maxc);
            exp_done.delete();
        end
        exp_va.delete();
        exp_ma.delete();
        exp_wr.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 2048; i++) vram_mem[i] = 16'($urandom);
    endtask

    logic [7:0] rl;
    int         n;

    initial begin
        for (int i = 0; i < 2048; i++) vram_mem[i] = 16'd0;
        repeat (3) @(negedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Directed line 0x2B: entry 0x5000+col, ROM word 0x4321, 1-cycle responders.
        for (int c = 0; c < 40; c++) vram_mem[{6'(c), 5'd5}] = 16'h5000 + 16'(c);
        start_line(8'h2B, 362);
        wait_done(1000);

        // Same line with acks echoed for an extra cycle.
        echo_mode = 1'b1;
        start_line(8'h2B, 362);
        wait_done(1000);
        echo_mode = 1'b0;

        // Random data, random 1..7 cycle ack delays, with and without echo.
        fill_random();
        rom_const = 1'b0;
        rand_dly  = 1'b1;
        for (int t = 0; t < 3; t++) begin
            echo_mode = 1'(t);
            rl = 8'($urandom);
            start_line(rl, 0);
            wait_done(4000);
        end
        echo_mode = 1'b0;
        rand_dly  = 1'b0;

        // A second linestart mid-line is ignored.
        start_line(8'h2B, 362);
        repeat (99) @(negedge clk);
        #1 line = 8'h10;
        linestart = 1'b1;
        @(negedge clk); #1 linestart = 1'b0;
        wait_done(1000);
        repeat (30) @(negedge clk);

        // Tile 0xFFF in the last column.
        rl = 8'($urandom);
        vram_mem[{6'd39, rl[7:3]}] = 16'hAFFF;
        start_line(rl, 362);
        wait_done(1000);
        repeat (20) @(negedge clk);

        // Reset mid-line at column 17 with a ROM ack still pending.
        fix_dly = 4;
        start_line(8'h2B, 0);
        n = 0;
        while (!(exp_wr.size() == 45 && msreq) && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL reset_setup column 17 not reached, writes_left=%0d", exp_wr.size());
        end
        rstn = 1'b0;
        exp_va.delete();
        exp_ma.delete();
        exp_wr.delete();
        exp_done.delete();
        @(negedge clk); #1 rstn = 1'b1;
        repeat (15) @(negedge clk);
        fix_dly = 1;
        start_line(8'h2B, 362);
        wait_done(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
